router_out_arbiter: RTL and testbench
=====================================

// Module: router_out_arbiter
// PURPOSE
//  Per-output-port scheduler for one RaveNoC router: shares one output link
//  (N/S/W/E/Local) among the router's input ports. Round-robin arbitration on
//  head flits, wormhole lock held until the tail flit, credit-based flow control
//  toward the downstream input buffer. Drives the crossbar mux select.
//  One instance per output port inside router_wrapper.
// PARAMETERS
//  NUM_REQ  5  number of requesting input ports
//  CREDITS  2  downstream buffer depth in flits; initial credit count
//  SW       $clog2(NUM_REQ) (localparam)  width of sel_o
//  CW       $clog2(CREDITS+1) (localparam)  width of credits_o
// PORTS
//  clk_noc      in   1        NoC clock
//  arst_noc     in   1        async reset, active-low
//  req_i        in   NUM_REQ  requester i holds a valid flit for this output
//  head_i       in   NUM_REQ  requester i's current flit is a head flit
//  tail_i       in   NUM_REQ  requester i's current flit is a tail flit (head&tail = single-flit pkt)
//  credit_ret_i in   1        downstream freed one buffer slot (1-cycle pulse)
//  grant_o      out  NUM_REQ  one-hot; flit of requester i transfers this cycle
//  flit_vld_o   out  1        a flit leaves on the output link this cycle (= |grant_o)
//  sel_o        out  SW       crossbar select; index of granted/locked requester
//  credits_o    out  CW       current credit count
//  locked_o     out  1        output currently owned by an in-flight packet
//  err_o        out  1        sticky protocol error; cleared only by reset
// BEHAVIOUR
//  Reset (arst_noc=0, async): state IDLE, rr_ptr=NUM_REQ-1 (req 0 first),
//   owner=0, credits=CREDITS, err=0; grant_o=0, flit_vld_o=0, sel_o=0,
//   locked_o=0, credits_o=CREDITS, err_o=0.
//  Grant is combinational (0-cycle latency) from req/head/tail/state/credits;
//   the flit transfers in the cycle grant_o[i]=1. No grant when credits==0.
//  IDLE: candidates = req_i & head_i. Non-head flits are ignored (no grant).
//   Pick first candidate searching rr_ptr+1, rr_ptr+2, ... mod NUM_REQ.
//   On grant to k: rr_ptr<=k; if tail_i[k] stay IDLE else -> LOCKED, owner<=k.
//  LOCKED: only owner may be granted: grant when req_i[owner] && credits>0.
//   sel_o=owner even with no grant. Granted flit with tail -> IDLE.
//   Owner flit with head_i=1 while LOCKED: err<=1, flit still forwarded as body.
//   Other requesters' flits are never granted while LOCKED.
//  locked_o = (state==LOCKED).
//  Credits: next = credits - flit_vld_o + credit_ret_i; send and return in
//   same cycle -> unchanged. Return when credits==CREDITS and no send ->
//   saturate at CREDITS, err<=1.
//  sel_o in IDLE with no grant = 0.
//  Reset mid-packet: lock and credits discarded; upstream/downstream reset together.
//  Owner's req_i drops mid-packet: stay LOCKED, wait (no timeout).
// TESTING
//  1. After reset, req_i=5'b00101, head=tail=5'b00101, CREDITS=2, credits return
//     each cycle -> grants 0,2,0,2 on consecutive cycles; locked_o stays 0.
//  2. Req 1 head (not tail) granted; req 3 head waits while req 1 sends body,
//     body, tail -> req 3 granted on cycle after tail; locked_o high 3 cycles.
//  3. CREDITS=2, no credit_ret_i, req 0 sends 4-flit packet -> 2 flits granted,
//     credits_o=0, grant_o=0 until credit_ret_i pulse, then 1 more flit.
//  4. flit_vld_o=1 and credit_ret_i=1 same cycle at credits=1 -> credits_o stays 1.
//  5. credit_ret_i at credits=CREDITS, idle -> credits_o=CREDITS, err_o=1 until reset;
//     separately, owner presents head while LOCKED -> err_o=1, flit granted.
//  6. arst_noc low mid-packet (LOCKED, credits=0) -> immediately locked_o=0,
//     grant_o=0, credits_o=CREDITS; after release, req 0 head wins first.

Source files
------------

// File: rtl/router_out_arbiter_if.sv
// Output-port scheduling bundle between a router's input ports and one
// output-link arbiter. The slave side is the arbiter.
interface router_out_arbiter_if #(
    parameter int NUM_REQ = 5,
    parameter int CREDITS = 2
);
    localparam int SW = $clog2(NUM_REQ);
    localparam int CW = $clog2(CREDITS + 1);

    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] head_i;
    logic [NUM_REQ-1:0] tail_i;
    logic               credit_ret_i;
    logic [NUM_REQ-1:0] grant_o;
    logic               flit_vld_o;
    logic [SW-1:0]      sel_o;
    logic [CW-1:0]      credits_o;
    logic               locked_o;
    logic               err_o;

    modport slave (
        input  req_i, head_i, tail_i, credit_ret_i,
        output grant_o, flit_vld_o, sel_o, credits_o, locked_o, err_o
    );

    modport master (
        output req_i, head_i, tail_i, credit_ret_i,
        input  grant_o, flit_vld_o, sel_o, credits_o, locked_o, err_o
    );
endinterface

// File: rtl/router_out_arbiter.sv
// Per-output-port wormhole scheduler: round-robin on head flits, lock until
// tail, credit-based flow control toward the downstream input buffer.
module router_out_arbiter #(
    parameter int NUM_REQ = 5,
    parameter int CREDITS = 2
) (
    input  logic                  clk_noc,
    input  logic                  arst_noc,
    router_out_arbiter_if.slave   bus
);
    localparam int SW = $clog2(NUM_REQ);
    localparam int CW = $clog2(CREDITS + 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [SW-1:0]      r_rr_ptr;
    logic [SW-1:0]      w_rr_ptr_next;
    logic [SW-1:0]      r_owner;
    logic [SW-1:0]      w_owner_next;
    logic [CW-1:0]      r_credits;
    logic [CW-1:0]      w_credits_next;
    logic               r_err;
    logic               w_err_next;

    logic [NUM_REQ-1:0] w_cand;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_found;
    logic [SW-1:0]      w_pick;
    logic               w_has_credit;
    logic               w_grant_vld;
    logic [SW-1:0]      w_grant_idx;

    assign w_cand       = bus.req_i & bus.head_i;
    assign w_has_credit = (r_credits != '0);

    // Scan from the farthest offset down so the nearest candidate after rr_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            if (w_cand[(int'(r_rr_ptr) + off) % NUM_REQ]) begin
                w_found = 1'b1;
                w_pick  = SW'((int'(r_rr_ptr) + off) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_rr_ptr_next  = r_rr_ptr;
        w_owner_next   = r_owner;
        w_err_next     = r_err;
        w_credits_next = r_credits;
        w_grant_vld    = 1'b0;
        w_grant_idx    = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_has_credit && w_found) begin
                    w_grant_vld   = 1'b1;
                    w_grant_idx   = w_pick;
                    w_rr_ptr_next = w_pick;
                    if (!bus.tail_i[w_pick]) begin
                        w_state_next = ST_LOCKED;
                        w_owner_next = w_pick;
                    end
                end
            end
            ST_LOCKED: begin
                // Select stays on the owner even while it stalls.
                w_grant_idx = r_owner;
                if (bus.req_i[r_owner] && w_has_credit) begin
                    w_grant_vld = 1'b1;
                    if (bus.head_i[r_owner]) begin
                        w_err_next = 1'b1;
                    end
                    if (bus.tail_i[r_owner]) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_grant_vld && !bus.credit_ret_i) begin
            w_credits_next = r_credits - CW'(1);
        end else if (!w_grant_vld && bus.credit_ret_i) begin
            if (r_credits == CW'(CREDITS)) begin
                w_err_next = 1'b1;
            end else begin
                w_credits_next = r_credits + CW'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign w_grant[gi] = w_grant_vld && (w_grant_idx == SW'(gi));
        end
    endgenerate

    always_ff @(posedge clk_noc or negedge arst_noc) begin
        if (!arst_noc) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= SW'(NUM_REQ - 1);
            r_owner   <= '0;
            r_credits <= CW'(CREDITS);
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_rr_ptr  <= w_rr_ptr_next;
            r_owner   <= w_owner_next;
            r_credits <= w_credits_next;
            r_err     <= w_err_next;
        end
    end

    assign bus.grant_o    = w_grant;
    assign bus.flit_vld_o = w_grant_vld;
    assign bus.sel_o      = w_grant_idx;
    assign bus.credits_o  = r_credits;
    assign bus.locked_o   = (r_state == ST_LOCKED);
    assign bus.err_o      = r_err;
endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter with NUM_REQ=5, CREDITS=2.
module tb_router_out_arbiter;
    logic clk_noc  = 1'b0;
    logic arst_noc = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    router_out_arbiter_if #(.NUM_REQ(5), .CREDITS(2)) bus();

    router_out_arbiter #(.NUM_REQ(5), .CREDITS(2)) dut (
        .clk_noc  (clk_noc),
        .arst_noc (arst_noc),
        .bus      (bus)
    );

    always #5 clk_noc = ~clk_noc;

    task automatic tick();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic drive(input logic [4:0] req, input logic [4:0] head,
                         input logic [4:0] tail, input logic ret);
        bus.req_i        = req;
        bus.head_i       = head;
        bus.tail_i       = tail;
        bus.credit_ret_i = ret;
    endtask

    task automatic do_reset();
        drive(5'b0, 5'b0, 5'b0, 1'b0);
        arst_noc = 1'b0;
        tick();
        tick();
        arst_noc = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #3;
        $display("reset: grant=%b vld=%b sel=%0d cr=%0d lk=%b err=%b", bus.grant_o,
                 bus.flit_vld_o, bus.sel_o, bus.credits_o, bus.locked_o, bus.err_o);
        checks++; if (bus.grant_o !== 5'b0) begin errors++; $display("FAIL reset_grant got %b exp 00000", bus.grant_o); end
        checks++; if (bus.flit_vld_o !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", bus.flit_vld_o); end
        checks++; if (bus.sel_o !== 3'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", bus.sel_o); end
        checks++; if (bus.locked_o !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", bus.locked_o); end
        checks++; if (bus.credits_o !== 2'd2) begin errors++; $display("FAIL reset_credits got %0d exp 2", bus.credits_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err_o); end
    endtask

    // Single-flit packets from 0 and 2 alternate; credits returned every cycle.
    task automatic test_round_robin();
        logic [4:0] exp_g [4];
        logic [2:0] exp_s [4];
        exp_g = '{5'b00001, 5'b00100, 5'b00001, 5'b00100};
        exp_s = '{3'd0, 3'd2, 3'd0, 3'd2};
        for (int i = 0; i < 4; i++) begin
            tick();
            drive(5'b00101, 5'b00101, 5'b00101, 1'b1);
            #3;
            $display("rr cyc %0d: grant=%b sel=%0d cr=%0d lk=%b", i, bus.grant_o, bus.sel_o,
                     bus.credits_o, bus.locked_o);
            checks++; if (bus.grant_o !== exp_g[i]) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", i, bus.grant_o, exp_g[i]); end
            checks++; if (bus.sel_o !== exp_s[i]) begin errors++; $display("FAIL rr_sel[%0d] got %0d exp %0d", i, bus.sel_o, exp_s[i]); end
            checks++; if (bus.locked_o !== 1'b0) begin errors++; $display("FAIL rr_locked[%0d] got %b exp 0", i, bus.locked_o); end
            checks++; if (bus.credits_o !== 2'd2) begin errors++; $display("FAIL rr_credits[%0d] got %0d exp 2", i, bus.credits_o); end
        end
    endtask

    // Req 1 holds the link for head/body/body/tail; req 3 waits for it.
    task automatic test_wormhole();
        logic [4:0] t_req [5];
        logic [4:0] t_head [5];
        logic [4:0] t_tail [5];
        logic [4:0] exp_g [5];
        logic       exp_l [5];
        logic [2:0] exp_s [5];
        t_req  = '{5'b00010, 5'b01010, 5'b01010, 5'b01010, 5'b01000};
        t_head = '{5'b00010, 5'b01000, 5'b01000, 5'b01000, 5'b01000};
        t_tail = '{5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b01000};
        exp_g  = '{5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b01000};
        exp_l  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_s  = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd3};
        for (int i = 0; i < 5; i++) begin
            tick();
            drive(t_req[i], t_head[i], t_tail[i], 1'b1);
            #3;
            $display("wh cyc %0d: grant=%b sel=%0d lk=%b", i, bus.grant_o, bus.sel_o, bus.locked_o);
            checks++; if (bus.grant_o !== exp_g[i]) begin errors++; $display("FAIL wh_grant[%0d] got %b exp %b", i, bus.grant_o, exp_g[i]); end
            checks++; if (bus.locked_o !== exp_l[i]) begin errors++; $display("FAIL wh_locked[%0d] got %b exp %b", i, bus.locked_o, exp_l[i]); end
            checks++; if (bus.sel_o !== exp_s[i]) begin errors++; $display("FAIL wh_sel[%0d] got %0d exp %0d", i, bus.sel_o, exp_s[i]); end
        end
        tick();
        drive(5'b0, 5'b0, 5'b0, 1'b0);
    endtask

    // Credit exhaustion, stall, single return, and send+return at credits=1.
    task automatic test_credits();
        logic [4:0] t_head [10];
        logic [4:0] t_tail [10];
        logic [4:0] t_req  [10];
        logic       t_ret  [10];
        logic [4:0] exp_g  [10];
        logic [1:0] exp_c  [10];
        logic       exp_l  [10];
        do_reset();
        t_req  = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001,
                   5'b00001, 5'b00001, 5'b00001, 5'b00000, 5'b00000};
        t_head = '{5'b00001, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0};
        t_tail = '{5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b00001, 5'b0, 5'b0};
        t_ret  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_g  = '{5'b00001, 5'b00001, 5'b0, 5'b0, 5'b0,
                   5'b00001, 5'b0, 5'b00001, 5'b0, 5'b0};
        exp_c  = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2};
        exp_l  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            tick();
            drive(t_req[i], t_head[i], t_tail[i], t_ret[i]);
            #3;
            $display("cr cyc %0d: grant=%b vld=%b cr=%0d lk=%b", i, bus.grant_o, bus.flit_vld_o,
                     bus.credits_o, bus.locked_o);
            checks++; if (bus.grant_o !== exp_g[i]) begin errors++; $display("FAIL cr_grant[%0d] got %b exp %b", i, bus.grant_o, exp_g[i]); end
            checks++; if (bus.flit_vld_o !== (|exp_g[i])) begin errors++; $display("FAIL cr_vld[%0d] got %b exp %b", i, bus.flit_vld_o, |exp_g[i]); end
            checks++; if (bus.credits_o !== exp_c[i]) begin errors++; $display("FAIL cr_credits[%0d] got %0d exp %0d", i, bus.credits_o, exp_c[i]); end
            checks++; if (bus.locked_o !== exp_l[i]) begin errors++; $display("FAIL cr_locked[%0d] got %b exp %b", i, bus.locked_o, exp_l[i]); end
            checks++; if (bus.sel_o !== 3'd0) begin errors++; $display("FAIL cr_sel[%0d] got %0d exp 0", i, bus.sel_o); end
        end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL cr_err got %b exp 0", bus.err_o); end
    endtask

    // Credit over-return and head-while-locked both set the sticky error.
    task automatic test_errors();
        logic [4:0] t_req  [4];
        logic [4:0] t_head [4];
        logic [4:0] t_tail [4];
        logic [4:0] exp_g  [4];
        logic       exp_e  [4];
        logic       exp_l  [4];
        tick();
        drive(5'b0, 5'b0, 5'b0, 1'b1);
        #3;
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL ovf_err_before got %b exp 0", bus.err_o); end
        tick();
        drive(5'b0, 5'b0, 5'b0, 1'b0);
        #3;
        $display("ovf: cr=%0d err=%b", bus.credits_o, bus.err_o);
        checks++; if (bus.credits_o !== 2'd2) begin errors++; $display("FAIL ovf_credits got %0d exp 2", bus.credits_o); end
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL ovf_err got %b exp 1", bus.err_o); end
        tick();
        #3;
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL ovf_err_sticky got %b exp 1", bus.err_o); end
        do_reset();
        #3;
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL err_cleared got %b exp 0", bus.err_o); end

        t_req  = '{5'b00001, 5'b00011, 5'b00001, 5'b00000};
        t_head = '{5'b00001, 5'b00011, 5'b00000, 5'b00000};
        t_tail = '{5'b00000, 5'b00000, 5'b00001, 5'b00000};
        exp_g  = '{5'b00001, 5'b00001, 5'b00001, 5'b00000};
        exp_e  = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_l  = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            tick();
            drive(t_req[i], t_head[i], t_tail[i], 1'b1);
            #3;
            $display("hd cyc %0d: grant=%b err=%b lk=%b", i, bus.grant_o, bus.err_o, bus.locked_o);
            checks++; if (bus.grant_o !== exp_g[i]) begin errors++; $display("FAIL hd_grant[%0d] got %b exp %b", i, bus.grant_o, exp_g[i]); end
            checks++; if (bus.err_o !== exp_e[i]) begin errors++; $display("FAIL hd_err[%0d] got %b exp %b", i, bus.err_o, exp_e[i]); end
            checks++; if (bus.locked_o !== exp_l[i]) begin errors++; $display("FAIL hd_locked[%0d] got %b exp %b", i, bus.locked_o, exp_l[i]); end
        end
    endtask

    // Async reset while locked with zero credits, then fresh arbitration.
    task automatic test_reset_mid_packet();
        do_reset();
        tick();
        drive(5'b00001, 5'b00001, 5'b00000, 1'b0);
        tick();
        drive(5'b00001, 5'b00000, 5'b00000, 1'b0);
        tick();
        #3;
        checks++; if (bus.locked_o !== 1'b1) begin errors++; $display("FAIL mid_locked_pre got %b exp 1", bus.locked_o); end
        checks++; if (bus.credits_o !== 2'd0) begin errors++; $display("FAIL mid_credits_pre got %0d exp 0", bus.credits_o); end
        #1;
        arst_noc = 1'b0;
        #1;
        $display("mid rst: grant=%b cr=%0d lk=%b", bus.grant_o, bus.credits_o, bus.locked_o);
        checks++; if (bus.locked_o !== 1'b0) begin errors++; $display("FAIL mid_locked got %b exp 0", bus.locked_o); end
        checks++; if (bus.grant_o !== 5'b0) begin errors++; $display("FAIL mid_grant got %b exp 00000", bus.grant_o); end
        checks++; if (bus.credits_o !== 2'd2) begin errors++; $display("FAIL mid_credits got %0d exp 2", bus.credits_o); end
        tick();
        arst_noc = 1'b1;
        drive(5'b00101, 5'b00101, 5'b00101, 1'b0);
        #3;
        $display("post rst: grant=%b sel=%0d", bus.grant_o, bus.sel_o);
        checks++; if (bus.grant_o !== 5'b00001) begin errors++; $display("FAIL post_grant got %b exp 00001", bus.grant_o); end
        checks++; if (bus.sel_o !== 3'd0) begin errors++; $display("FAIL post_sel got %0d exp 0", bus.sel_o); end
        tick();
        drive(5'b0, 5'b0, 5'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wormhole();
        test_credits();
        test_errors();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
